// File: rtl/risc5_memctrl_pkg.sv
// Shared definitions for the RISC5 memory controller: FSM encoding, address-map constants and lane decode.
package risc5_memctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } mc_state_e;

  localparam logic [23:0] IO_BASE         = 24'hFFFFC0;
  localparam logic [9:0]  PROM_PAGE       = 10'h3FF;
  localparam int          WAIT_STATES_MAX = 7;

  // Active-low byte-lane strobes {ub_n, lb_n}: both lanes for a word, else the lane picked by adr[0].
  function automatic logic [1:0] lane_mask(input logic ben, input logic a0);
    if (!ben) begin
      return 2'b00;
    end else if (a0) begin
      return 2'b01;
    end else begin
      return 2'b10;
    end
  endfunction

endpackage

// File: rtl/risc5_memctrl_sram_phase.sv
// One SRAM halfword phase: WAIT_STATES+1 cycles of registered strobes, with done on the last cycle.
module risc5_memctrl_sram_phase
  import risc5_memctrl_pkg::*;
#(
  parameter int SRAM_AW     = 18,
  parameter int WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               write,
  input  logic               half,
  input  logic [SRAM_AW-2:0] word_adr,
  input  logic [15:0]        data,
  input  logic [1:0]         lanes,
  output logic               done,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int          WS_EFF = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
  localparam logic [2:0]  LAST   = 3'(WS_EFF);

  logic       active_r;
  logic       write_r;
  logic [2:0] cnt_r;

  assign done = active_r && (cnt_r == LAST);

  // Phase timer and strobe registers; we_n releases one cycle before the phase ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_r   <= 1'b0;
      write_r    <= 1'b0;
      cnt_r      <= 3'd0;
      sram_a     <= '0;
      sram_dq_o  <= 16'h0000;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
    end else if (start) begin
      active_r   <= 1'b1;
      write_r    <= write;
      cnt_r      <= 3'd0;
      sram_a     <= {word_adr, half};
      sram_dq_o  <= data;
      sram_dq_oe <= write;
      sram_ce_n  <= 1'b0;
      sram_oe_n  <= write;
      sram_we_n  <= ~write;
      {sram_ub_n, sram_lb_n} <= lanes;
    end else if (active_r) begin
      if (cnt_r == LAST) begin
        active_r   <= 1'b0;
        sram_dq_oe <= 1'b0;
        sram_ce_n  <= 1'b1;
        sram_oe_n  <= 1'b1;
        sram_we_n  <= 1'b1;
        sram_ub_n  <= 1'b1;
        sram_lb_n  <= 1'b1;
      end else begin
        cnt_r     <= cnt_r + 3'd1;
        sram_we_n <= !(write_r && ((cnt_r + 3'd1) != LAST));
      end
    end
  end

endmodule

// File: rtl/risc5_memctrl.sv
// RISC5 memory controller: 32-bit fetch/load/store over a 16-bit async SRAM in two halfword phases.
// Optional one-entry fetch buffer enabled by defining RISC5_MEMCTRL_FETCH_BUF_EN.
module risc5_memctrl
  import risc5_memctrl_pkg::*;
#(
  parameter int SRAM_AW     = 18,
  parameter int WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [23:0]        adr,
  input  logic               rd,
  input  logic               wr,
  input  logic               ben,
  input  logic [31:0]        outbus,
  output logic [31:0]        inbus,
  output logic [31:0]        codebus,
  output logic               memwait,
  output logic [SRAM_AW-1:0] sram_a,
  input  logic [15:0]        sram_dq_i,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  mc_state_e          state_r;
  logic               wr_r, rd_r, byte_r;
  logic [1:0]         lanes_r;
  logic [SRAM_AW-2:0] word_r;
  logic [15:0]        hi_data_r, lo_rd_r;

  logic               is_io_s, is_prom_s, hit_s, sram_req_s;
  logic               start_s, done_s, finish_s, p_write_s, p_half_s;
  logic [SRAM_AW-2:0] p_word_s;
  logic [15:0]        p_data_s;
  logic [1:0]         p_lanes_s;
  logic [31:0]        result_s;

`ifdef RISC5_MEMCTRL_FETCH_BUF_EN
  logic [21:0] tag_r, fb_tag_r;
  logic        fb_valid_r;
`endif

  // Request classification and CPU freeze.
  always_comb begin
    is_io_s   = (rd | wr) && (adr[23:6] == IO_BASE[23:6]);
    is_prom_s = !(rd | wr) && (adr[23:14] == PROM_PAGE);
`ifdef RISC5_MEMCTRL_FETCH_BUF_EN
    hit_s     = !(rd | wr) && fb_valid_r && (fb_tag_r == adr[23:2]);
`else
    hit_s     = 1'b0;
`endif
    sram_req_s = !is_io_s && !is_prom_s && !hit_s;
    memwait    = rst && sram_req_s && (state_r != ST_DONE);
  end

  // Phase sequencing: IDLE launches from live inputs, LO->HI continues from the latched request.
  always_comb begin
    finish_s = done_s && ((state_r == ST_HI) || byte_r);
    start_s  = ((state_r == ST_IDLE) && sram_req_s) ||
               ((state_r == ST_LO) && done_s && !byte_r);
    if (state_r == ST_IDLE) begin
      p_write_s = wr;
      p_half_s  = ben & adr[1];
      p_word_s  = adr[SRAM_AW:2];
      p_lanes_s = lane_mask(ben, adr[0]);
      p_data_s  = (ben & adr[1]) ? outbus[31:16] : outbus[15:0];
    end else begin
      p_write_s = wr_r;
      p_half_s  = 1'b1;
      p_word_s  = word_r;
      p_lanes_s = lanes_r;
      p_data_s  = hi_data_r;
    end
    if (!byte_r) begin
      result_s = {sram_dq_i, lo_rd_r};
    end else if (state_r == ST_HI) begin
      result_s = {sram_dq_i, 16'h0000};
    end else begin
      result_s = {16'h0000, sram_dq_i};
    end
  end

  risc5_memctrl_sram_phase #(
    .SRAM_AW    (SRAM_AW),
    .WAIT_STATES(WAIT_STATES)
  ) u_phase (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s),
    .write     (p_write_s),
    .half      (p_half_s),
    .word_adr  (p_word_s),
    .data      (p_data_s),
    .lanes     (p_lanes_s),
    .done      (done_s),
    .sram_a    (sram_a),
    .sram_dq_o (sram_dq_o),
    .sram_dq_oe(sram_dq_oe),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n)
  );

  // Access FSM, request latch and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      wr_r      <= 1'b0;
      rd_r      <= 1'b0;
      byte_r    <= 1'b0;
      lanes_r   <= 2'b11;
      word_r    <= '0;
      hi_data_r <= 16'h0000;
      lo_rd_r   <= 16'h0000;
      inbus     <= 32'h0000_0000;
      codebus   <= 32'h0000_0000;
`ifdef RISC5_MEMCTRL_FETCH_BUF_EN
      tag_r      <= 22'd0;
      fb_tag_r   <= 22'd0;
      fb_valid_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sram_req_s) begin
            wr_r      <= wr;
            rd_r      <= rd & ~wr;
            byte_r    <= ben;
            lanes_r   <= lane_mask(ben, adr[0]);
            word_r    <= adr[SRAM_AW:2];
            hi_data_r <= outbus[31:16];
`ifdef RISC5_MEMCTRL_FETCH_BUF_EN
            tag_r <= adr[23:2];
            if (wr && (fb_tag_r == adr[23:2])) begin
              fb_valid_r <= 1'b0;
            end
`endif
            state_r <= (ben && adr[1]) ? ST_HI : ST_LO;
          end
        end
        ST_LO: begin
          if (done_s) begin
            if (!wr_r) begin
              lo_rd_r <= sram_dq_i;
            end
            state_r <= byte_r ? ST_DONE : ST_HI;
          end
        end
        ST_HI: begin
          if (done_s) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
      if (finish_s && !wr_r) begin
        if (rd_r) begin
          inbus <= result_s;
        end else begin
          codebus <= result_s;
`ifdef RISC5_MEMCTRL_FETCH_BUF_EN
          fb_tag_r   <= tag_r;
          fb_valid_r <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_risc5_memctrl.sv
// Directed bench for risc5_memctrl: default instance (WAIT_STATES=1) plus a WAIT_STATES=3 instance.
module tb_risc5_memctrl;

  localparam logic [23:0] IDLE_ADR = 24'hFFE000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        dsel;
  logic        cpu_rd, cpu_wr, cpu_ben;
  logic [23:0] cpu_adr;
  logic [31:0] cpu_out;

  logic        rd0, wr0, ben0, rd1, wr1, ben1;
  logic [23:0] adr0, adr1;
  logic [31:0] inbus0, codebus0, inbus1, codebus1;
  logic        memwait0, memwait1;
  logic [17:0] a0, a1;
  logic [15:0] dqi0, dqo0, dqi1, dqo1;
  logic        oe0, ce_n0, oe_n0, we_n0, ub_n0, lb_n0;
  logic        oe1, ce_n1, oe_n1, we_n1, ub_n1, lb_n1;

  assign rd0  = !dsel && cpu_rd;
  assign wr0  = !dsel && cpu_wr;
  assign ben0 = !dsel && cpu_ben;
  assign adr0 = !dsel ? cpu_adr : IDLE_ADR;
  assign rd1  = dsel && cpu_rd;
  assign wr1  = dsel && cpu_wr;
  assign ben1 = dsel && cpu_ben;
  assign adr1 = dsel ? cpu_adr : IDLE_ADR;

  risc5_memctrl #(.SRAM_AW(18), .WAIT_STATES(1)) dut0 (
    .clk(clk), .rst(rst), .adr(adr0), .rd(rd0), .wr(wr0), .ben(ben0), .outbus(cpu_out),
    .inbus(inbus0), .codebus(codebus0), .memwait(memwait0), .sram_a(a0), .sram_dq_i(dqi0),
    .sram_dq_o(dqo0), .sram_dq_oe(oe0), .sram_ce_n(ce_n0), .sram_oe_n(oe_n0), .sram_we_n(we_n0),
    .sram_ub_n(ub_n0), .sram_lb_n(lb_n0));

  risc5_memctrl #(.SRAM_AW(18), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst), .adr(adr1), .rd(rd1), .wr(wr1), .ben(ben1), .outbus(cpu_out),
    .inbus(inbus1), .codebus(codebus1), .memwait(memwait1), .sram_a(a1), .sram_dq_i(dqi1),
    .sram_dq_o(dqo1), .sram_dq_oe(oe1), .sram_ce_n(ce_n1), .sram_oe_n(oe_n1), .sram_we_n(we_n1),
    .sram_ub_n(ub_n1), .sram_lb_n(lb_n1));

  // SRAM models with a preload port
  logic        ld_en;
  logic [9:0]  ld_a;
  logic [15:0] ld_d;
  logic [15:0] mem0 [0:1023];
  logic [15:0] mem1 [0:1023];

  assign dqi0 = (!ce_n0 && !oe_n0) ? mem0[a0[9:0]] : 16'h0000;
  assign dqi1 = (!ce_n1 && !oe_n1) ? mem1[a1[9:0]] : 16'h0000;

  always @(posedge clk) begin
    if (ld_en) begin
      mem0[ld_a] <= ld_d;
      mem1[ld_a] <= ld_d;
    end else begin
      if (!ce_n0 && !we_n0 && oe0) begin
        if (!lb_n0) mem0[a0[9:0]][7:0]  <= dqo0[7:0];
        if (!ub_n0) mem0[a0[9:0]][15:8] <= dqo0[15:8];
      end
      if (!ce_n1 && !we_n1 && oe1) begin
        if (!lb_n1) mem1[a1[9:0]][7:0]  <= dqo1[7:0];
        if (!ub_n1) mem1[a1[9:0]][15:8] <= dqo1[15:8];
      end
    end
  end

  logic        s_memwait, s_ce_n, s_we_n, s_ub_n, s_lb_n;
  logic [17:0] s_a;
  logic [15:0] s_dq_o;
  logic [31:0] s_inbus, s_codebus;
  assign s_memwait = dsel ? memwait1 : memwait0;
  assign s_ce_n    = dsel ? ce_n1 : ce_n0;
  assign s_we_n    = dsel ? we_n1 : we_n0;
  assign s_ub_n    = dsel ? ub_n1 : ub_n0;
  assign s_lb_n    = dsel ? lb_n1 : lb_n0;
  assign s_a       = dsel ? a1 : a0;
  assign s_dq_o    = dsel ? dqo1 : dqo0;
  assign s_inbus   = dsel ? inbus1 : inbus0;
  assign s_codebus = dsel ? codebus1 : codebus0;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int          waits, ce_cyc, we_cyc;
  logic [17:0] a_first, a_last;
  logic [1:0]  lanes_seen;
  logic [15:0] dqo_seen;

  task automatic load(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge on which the CPU advances.
  task automatic access(input logic r, input logic w, input logic b,
                        input logic [23:0] a, input logic [31:0] d);
    logic done_ok;
    cpu_rd = r; cpu_wr = w; cpu_ben = b; cpu_adr = a; cpu_out = d;
    waits = 0; ce_cyc = 0; we_cyc = 0; done_ok = 1'b0;
    a_first = 18'h0; a_last = 18'h0; lanes_seen = 2'b11; dqo_seen = 16'h0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!s_ce_n) begin
        if (ce_cyc == 0) a_first = s_a;
        a_last = s_a;
        lanes_seen = {s_ub_n, s_lb_n};
        dqo_seen = s_dq_o;
        ce_cyc++;
        if (!s_we_n) we_cyc++;
      end
      if (!s_memwait) begin
        done_ok = 1'b1;
        break;
      end
      waits++;
    end
    check_eq("access_completes", {31'd0, done_ok}, 32'd1);
    @(posedge clk);
    #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_ben = 1'b0; cpu_adr = IDLE_ADR;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rep_waits;
    int exp_rep_ce;
`ifdef RISC5_MEMCTRL_FETCH_BUF_EN
    exp_rep_waits = 0;
    exp_rep_ce    = 0;
`else
    exp_rep_waits = 5;
    exp_rep_ce    = 4;
`endif
    dsel = 1'b0; ld_en = 1'b0; ld_a = 10'd0; ld_d = 16'h0;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_ben = 1'b0; cpu_adr = 24'h000100; cpu_out = 32'h0;
    rst = 1'b0;
    load(10'h080, 16'hBEEF);
    load(10'h081, 16'hDEAD);
    load(10'h100, 16'h1234);
    load(10'h101, 16'hCAFE);

    // reset state, with an SRAM read request pending
    @(negedge clk);
    check_eq("rst_memwait0", {31'd0, memwait0}, 32'd0);
    check_eq("rst_memwait1", {31'd0, memwait1}, 32'd0);
    check_eq("rst_inbus", inbus0, 32'h0);
    check_eq("rst_codebus", codebus0, 32'h0);
    check_eq("rst_strobes", {26'd0, ce_n0, oe_n0, we_n0, ub_n0, lb_n0, oe0}, 32'h3E);
    check_eq("rst_sram_a", {14'd0, a0}, 32'h0);
    check_eq("rst_dq_o", {16'd0, dqo0}, 32'h0);
    cpu_rd = 1'b0; cpu_adr = IDLE_ADR;
    rst = 1'b1;
    @(posedge clk); #1;

    // word read
    access(1'b1, 1'b0, 1'b0, 24'h000100, 32'h0);
    check_eq("t1_waits", waits, 32'd5);
    check_eq("t1_inbus", s_inbus, 32'hDEADBEEF);
    check_eq("t1_a_first", {14'd0, a_first}, 32'h80);
    check_eq("t1_a_last", {14'd0, a_last}, 32'h81);
    check_eq("t1_ce_cycles", ce_cyc, 32'd4);

    // byte store into upper lane of upper half
    access(1'b0, 1'b1, 1'b1, 24'h000103, 32'h55555555);
    check_eq("t2_waits", waits, 32'd3);
    check_eq("t2_a", {14'd0, a_first}, 32'h81);
    check_eq("t2_lanes", {30'd0, lanes_seen}, 32'h1);
    check_eq("t2_data", {16'd0, dqo_seen}, 32'h5555);
    check_eq("t2_we_cycles", we_cyc, 32'd1);
    access(1'b1, 1'b0, 1'b0, 24'h000100, 32'h0);
    check_eq("t2_readback", s_inbus, 32'h55ADBEEF);
    access(1'b1, 1'b0, 1'b1, 24'h000102, 32'h0);
    check_eq("byte_hi_waits", waits, 32'd3);
    check_eq("byte_hi_inbus", s_inbus, 32'h55AD0000);
    access(1'b1, 1'b0, 1'b1, 24'h000101, 32'h0);
    check_eq("byte_lo_inbus", s_inbus, 32'h0000BEEF);

    // IO and PROM bypass
    access(1'b1, 1'b0, 1'b0, 24'hFFFFC4, 32'h0);
    check_eq("t3_io_waits", waits, 32'd0);
    check_eq("t3_io_ce", ce_cyc, 32'd0);
    check_eq("t3_io_inbus_held", s_inbus, 32'h0000BEEF);
    access(1'b0, 1'b0, 1'b0, 24'hFFE000, 32'h0);
    check_eq("t3_prom_waits", waits, 32'd0);
    check_eq("t3_prom_ce", ce_cyc, 32'd0);

    // fetches, repeated fetch, invalidating write
    access(1'b0, 1'b0, 1'b0, 24'h000200, 32'h0);
    check_eq("t4_fetch_waits", waits, 32'd5);
    check_eq("t4_codebus", s_codebus, 32'hCAFE1234);
    access(1'b0, 1'b0, 1'b0, 24'h000200, 32'h0);
    check_eq("t4_refetch_waits", waits, exp_rep_waits);
    check_eq("t4_refetch_ce", ce_cyc, exp_rep_ce);
    check_eq("t4_refetch_codebus", s_codebus, 32'hCAFE1234);
    access(1'b0, 1'b1, 1'b0, 24'h000200, 32'h0BADF00D);
    check_eq("t4_wr_waits", waits, 32'd5);
    check_eq("t4_wr_we_cycles", we_cyc, 32'd2);
    access(1'b0, 1'b0, 1'b0, 24'h000200, 32'h0);
    check_eq("t4_fetch2_waits", waits, 32'd5);
    check_eq("t4_fetch2_codebus", s_codebus, 32'h0BADF00D);

    // rd and wr together act as a store
    access(1'b1, 1'b1, 1'b0, 24'h000300, 32'h11112222);
    check_eq("rdwr_waits", waits, 32'd5);
    check_eq("rdwr_inbus_held", s_inbus, 32'h0000BEEF);
    access(1'b1, 1'b0, 1'b0, 24'h000300, 32'h0);
    check_eq("rdwr_readback", s_inbus, 32'h11112222);

    // reset during the HI phase
    cpu_rd = 1'b1; cpu_adr = 24'h000100;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check_eq("t5_in_hi_a", {14'd0, a0}, 32'h81);
    check_eq("t5_in_hi_ce", {31'd0, ce_n0}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("t5_ce_n", {31'd0, ce_n0}, 32'd1);
    check_eq("t5_oe_n", {31'd0, oe_n0}, 32'd1);
    check_eq("t5_inbus", inbus0, 32'h0);
    check_eq("t5_codebus", codebus0, 32'h0);
    check_eq("t5_memwait", {31'd0, memwait0}, 32'd0);
    cpu_rd = 1'b0; cpu_adr = IDLE_ADR;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 1'b0, 1'b0, 24'h000200, 32'h0);
    check_eq("t5_fetch_waits", waits, 32'd5);
    check_eq("t5_fetch_codebus", s_codebus, 32'h0BADF00D);

    // WAIT_STATES=3 instance
    dsel = 1'b1;
    access(1'b1, 1'b0, 1'b0, 24'h000100, 32'h0);
    check_eq("t6_word_waits", waits, 32'd9);
    check_eq("t6_word_inbus", s_inbus, 32'hDEADBEEF);
    access(1'b1, 1'b0, 1'b1, 24'h000102, 32'h0);
    check_eq("t6_byte_waits", waits, 32'd5);
    check_eq("t6_byte_inbus", s_inbus, 32'hDEAD0000);
    access(1'b0, 1'b1, 1'b1, 24'h000100, 32'h000000AB);
    check_eq("t6_bwr_waits", waits, 32'd5);
    check_eq("t6_bwr_we_cycles", we_cyc, 32'd3);
    check_eq("t6_bwr_lanes", {30'd0, lanes_seen}, 32'h2);
    access(1'b0, 1'b1, 1'b0, 24'h000104, 32'h12345678);
    check_eq("t6_wwr_waits", waits, 32'd9);
    check_eq("t6_wwr_we_cycles", we_cyc, 32'd6);
    access(1'b1, 1'b0, 1'b0, 24'h000104, 32'h0);
    check_eq("t6_wwr_readback", s_inbus, 32'h12345678);
    access(1'b1, 1'b0, 1'b0, 24'h000100, 32'h0);
    check_eq("t6_bwr_readback", s_inbus, 32'hDEADBEAB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
